// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Forwarding select encodings and the hazard class chosen each cycle.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  // Ordered from highest to lowest priority; exactly one class wins per cycle.
  typedef enum logic [1:0] {
    HZ_NONE    = 2'b00,
    HZ_MEM     = 2'b01,
    HZ_MSTRUCT = 2'b10,
    HZ_DATA    = 2'b11
  } hz_class_e;

  function automatic int mdu_cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Multi-cycle MDU busy tracker: loads the latency on issue, counts down to idle.
// Counting continues while the memory stage is frozen; only a new issue is held off.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold,
  output logic busy
);

  localparam int MDU_CNT_W = mdu_cnt_w(MDU_LATENCY);
  localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_LATENCY);

  logic [MDU_CNT_W-1:0] cnt;
  logic [MDU_CNT_W-1:0] cnt_next;
  logic                 issue;

  always_comb begin
    issue    = start && !busy && !hold;
    cnt_next = cnt;
    if (issue) begin
      cnt_next = LOAD_VAL;
    end else if (cnt != '0) begin
      cnt_next = cnt - MDU_CNT_W'(1);
    end
  end

  // Busy is kept as its own flop so it is a clean registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with MDU scoreboard,
// memory-wait freeze, prioritised stall/flush and saturating perf counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegM,
  input  logic                  BranchD,
  input  logic                  JumpRegD,
  input  logic                  PCSrcD,
  input  logic                  MduStartE,
  input  logic                  MduReadD,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic                  MduBusy,
  output logic [CNT_W-1:0]      StallCycles,
  output logic [CNT_W-1:0]      RedirectCount
);

  function automatic fwd_sel_e fwd_ex(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] wr_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] wr_w,
    input logic                  we_w
  );
    if (src == '0)                   return FWD_NONE;
    else if (we_m && src == wr_m)    return FWD_M;
    else if (we_w && src == wr_w)    return FWD_W;
    else                             return FWD_NONE;
  endfunction

  // Branch operands are compared in D, so any producer still in E, or a load in M, must stall.
  function automatic logic br_dep(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] wr_e,
    input logic                  we_e,
    input logic [REG_ADDR_W-1:0] wr_m,
    input logic                  ld_m
  );
    return (src != '0) && ((we_e && src == wr_e) || (ld_m && src == wr_m));
  endfunction

  fwd_sel_e  fwd_a_e;
  fwd_sel_e  fwd_b_e;
  hz_class_e hz_class;
  logic      lwstall;
  logic      brstall;
  logic      rdstall;
  logic      memstall;
  logic      mstruct;

  always_comb begin
    fwd_a_e = fwd_ex(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    fwd_b_e = fwd_ex(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  end

  assign ForwardAE = fwd_a_e;
  assign ForwardBE = fwd_b_e;
  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  assign lwstall  = MemtoRegE && (WriteRegE != '0) &&
                    ((RsD == WriteRegE) || (RtD == WriteRegE));
  assign brstall  = (BranchD &&
                     (br_dep(RsD, WriteRegE, RegWriteE, WriteRegM, MemtoRegM) ||
                      br_dep(RtD, WriteRegE, RegWriteE, WriteRegM, MemtoRegM))) ||
                    (JumpRegD && br_dep(RsD, WriteRegE, RegWriteE, WriteRegM, MemtoRegM));
  assign rdstall  = MduReadD && MduBusy;
  assign memstall = MemReqM && !MemReadyM;
  assign mstruct  = MduStartE && MduBusy;

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    hz_class = HZ_NONE;
    if (memstall) begin
      hz_class = HZ_MEM;
    end else if (mstruct) begin
      hz_class = HZ_MSTRUCT;
    end else if (lwstall || brstall || rdstall) begin
      hz_class = HZ_DATA;
    end
    if (!reset) begin
      unique case (hz_class)
        HZ_MEM: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end
        HZ_MSTRUCT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
        HZ_DATA: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        default: begin
          // Only reachable with D unstalled, so a redirect can never squash a held instruction.
          FlushD = PCSrcD || JumpRegD;
        end
      endcase
    end
  end

  mdu_scoreboard #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_scoreboard (
    .clk   (CLK),
    .reset (reset),
    .start (MduStartE),
    .hold  (memstall),
    .busy  (MduBusy)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      StallCycles   <= '0;
      RedirectCount <= '0;
    end else begin
      if (StallF && (StallCycles != '1)) begin
        StallCycles <= StallCycles + CNT_W'(1);
      end
      if (FlushD && (RedirectCount != '1)) begin
        RedirectCount <= RedirectCount + CNT_W'(1);
      end
    end
  end

endmodule
